mac_layer_engine: RTL and testbench

MAC_LAYER_ENGINE -- requirements
Module: mac_layer_engine

---
 rtl/mac_layer_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_mac_layer_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_layer_engine.sv
// ---------------------------------------------------------------------------
// mac_layer_engine
//
// Fully-connected layer engine. Computes N_OUT neuron outputs, N_CH lanes at
// a time, as signed fixed-point dot products of an N_IN-long input vector
// (input SRAM) against per-neuron weight rows (weight SRAM, one packed word
// of N_CH lane weights per address). Results are rescaled by FRAC,
// saturated to DW bits, optionally ReLU-clamped, and streamed out with a
// valid/ready handshake.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low
//   start      begin a layer pass (accepted in IDLE only)
//   relu_en    clamp negative outputs to zero (latched at start acceptance)
//   x_re       input SRAM read enable
//   x_addr     input SRAM address (term index i)
//   x_q        input SRAM data, valid one cycle after x_re
//   w_re       weight SRAM read enable
//   w_addr     weight SRAM address (g*N_IN + i)
//   w_q        packed lane weights, lane 0 in the LSBs, valid one cycle after w_re
//   out_valid  result available
//   out_data   result value
//   out_idx    result neuron index (g*N_CH + lane)
//   out_ready  consumer ready; a transfer is out_valid && out_ready
//   busy       pass in progress
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
//  state  | meaning
//  IDLE   | waiting for start
//  RUN    | issuing one input/weight read per cycle for the current group
//  DRAIN  | two cycles letting the read/multiply pipeline empty into the accs
//  EMIT   | streaming lanes 0..N_CH-1 of the current group
//  FIN    | done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module mac_layer_engine #(
    parameter int N_CH  = 10,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int N_IN  = 64,
    parameter int N_OUT = 20,
    parameter int AW_X  = 10,
    parameter int AW_W  = 18
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        relu_en,
    output logic                                        x_re,
    output logic [AW_X-1:0]                             x_addr,
    input  logic [DW-1:0]                               x_q,
    output logic                                        w_re,
    output logic [AW_W-1:0]                             w_addr,
    input  logic [N_CH*DW-1:0]                          w_q,
    output logic                                        out_valid,
    output logic [DW-1:0]                               out_data,
    output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] out_idx,
    input  logic                                        out_ready,
    output logic                                        busy,
    output logic                                        done
);

    localparam int N_GRP = N_OUT / N_CH;
    localparam int ACC_W = 2*DW + 8;
    localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam int LW    = (N_CH  > 1) ? $clog2(N_CH)  : 1;
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [GW-1:0] G_LAST = GW'(N_GRP - 1);
    localparam logic [LW-1:0] L_LAST = LW'(N_CH - 1);

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_EMIT,
        S_FIN
    } state_t;

    state_t                   state;
    logic [GW-1:0]            g;
    logic [IW-1:0]            i;
    logic [LW-1:0]            lane;
    logic                     dcnt;
    logic                     relu_q;
    logic [AW_W-1:0]          w_base;

    logic                     d_v;
    logic                     p_v;
    logic signed [2*DW-1:0]   prod [N_CH];
    logic signed [ACC_W-1:0]  acc  [N_CH];

    logic                     xfer;
    logic                     acc_clr;

    assign xfer = out_valid && out_ready;

    // Accumulators clear whenever a new group starts its RUN phase.
    assign acc_clr = ((state == S_IDLE) && start) ||
                     ((state == S_EMIT) && xfer && (lane == L_LAST) && (g != G_LAST));

    // Rescale (floor shift), optional ReLU, then saturate to DW bits.
    function automatic logic [DW-1:0] to_out(input logic signed [ACC_W-1:0] a,
                                             input logic relu);
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC;
        if (relu && (s < 0))
            return '0;
        else if (s > SAT_HI)
            return SAT_HI[DW-1:0];
        else if (s < SAT_LO)
            return SAT_LO[DW-1:0];
        else
            return s[DW-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            g         <= '0;
            i         <= '0;
            lane      <= '0;
            dcnt      <= 1'b0;
            relu_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x_re      <= 1'b0;
            w_re      <= 1'b0;
            x_addr    <= '0;
            w_addr    <= '0;
            w_base    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_RUN;
                        g       <= '0;
                        i       <= '0;
                        lane    <= '0;
                        relu_q  <= relu_en;
                        busy    <= 1'b1;
                        x_re    <= 1'b1;
                        w_re    <= 1'b1;
                        x_addr  <= '0;
                        w_addr  <= '0;
                        w_base  <= '0;
                        out_idx <= '0;
                    end
                end
                S_RUN: begin
                    if (i == I_LAST) begin
                        state <= S_DRAIN;
                        dcnt  <= 1'b0;
                        x_re  <= 1'b0;
                        w_re  <= 1'b0;
                    end else begin
                        i      <= i + IW'(1);
                        x_addr <= x_addr + AW_X'(1);
                        w_addr <= w_addr + AW_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Two cycles: the last read's data lands, then its product
                    // is accumulated on the edge that enters EMIT.
                    if (dcnt) begin
                        state     <= S_EMIT;
                        lane      <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        dcnt <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (xfer) begin
                        out_idx <= out_idx + OW'(1);
                        if (lane == L_LAST) begin
                            out_valid <= 1'b0;
                            lane      <= '0;
                            if (g == G_LAST) begin
                                state <= S_FIN;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state  <= S_RUN;
                                g      <= g + GW'(1);
                                i      <= '0;
                                x_re   <= 1'b1;
                                w_re   <= 1'b1;
                                x_addr <= '0;
                                w_addr <= w_base + AW_W'(N_IN);
                                w_base <= w_base + AW_W'(N_IN);
                            end
                        end else begin
                            lane <= lane + LW'(1);
                        end
                    end
                end
                S_FIN: begin
                    done    <= 1'b0;
                    out_idx <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data -> registered lane products -> accumulators.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_v <= 1'b0;
            p_v <= 1'b0;
            for (int l = 0; l < N_CH; l++) begin
                prod[l] <= '0;
                acc[l]  <= '0;
            end
        end else begin
            d_v <= x_re;
            p_v <= d_v;
            for (int l = 0; l < N_CH; l++) begin
                if (d_v)
                    prod[l] <= (2*DW)'($signed(x_q)) * (2*DW)'($signed(w_q[l*DW +: DW]));
                if (acc_clr)
                    acc[l] <= '0;
                else if (p_v)
                    acc[l] <= acc[l] + ACC_W'(prod[l]);
            end
        end
    end

    // Accumulators are frozen during EMIT, so the selected lane's converted
    // value stays stable for as long as the consumer stalls.
    always_comb begin
        out_data = '0;
        if (out_valid)
            out_data = to_out(acc[lane], relu_q);
    end

endmodule

// File: tb/tb_mac_layer_engine.sv
module tb_mac_layer_engine;

    localparam int N_CH  = 2;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int AW_X  = 10;
    localparam int AW_W  = 18;
    localparam int N_GRP = N_OUT / N_CH;
    localparam int OW    = $clog2(N_OUT);
    localparam int PASS_CYC = N_GRP * (N_IN + 2 + N_CH);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  relu_en;
    logic                  x_re;
    logic [AW_X-1:0]       x_addr;
    logic [DW-1:0]         x_q;
    logic                  w_re;
    logic [AW_W-1:0]       w_addr;
    logic [N_CH*DW-1:0]    w_q;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic [OW-1:0]         out_idx;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    logic [DW-1:0]         xmem [N_IN];
    logic [N_CH*DW-1:0]    wmem [N_GRP*N_IN];

    int n_checks = 0;
    int n_errors = 0;

    mac_layer_engine #(
        .N_CH(N_CH), .DW(DW), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT),
        .AW_X(AW_X), .AW_W(AW_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .x_re(x_re), .x_addr(x_addr), .x_q(x_q),
        .w_re(w_re), .w_addr(w_addr), .w_q(w_q),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM models with one cycle read latency.
    always @(posedge clk) begin
        if (x_re) x_q <= xmem[x_addr[1:0]];
        if (w_re) w_q <= wmem[w_addr[2:0]];
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: output j is the dot product of x with neuron j's weights,
    // floor-divided by 2^FRAC, ReLU'd if requested, and clamped to DW bits.
    function automatic logic [DW-1:0] ref_out(input int j, input bit relu);
        longint sum;
        int grp, ln;
        logic [DW-1:0] wv;
        sum = 0;
        grp = j / N_CH;
        ln  = j % N_CH;
        for (int k = 0; k < N_IN; k++) begin
            wv  = wmem[grp*N_IN + k][ln*DW +: DW];
            sum += longint'($signed(xmem[k])) * longint'($signed(wv));
        end
        sum = sum >>> FRAC;
        if (relu && sum < 0) sum = 0;
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        return sum[DW-1:0];
    endfunction

    task automatic fill(input logic [DW-1:0] xv, input logic [DW-1:0] wv, input bit rnd);
        for (int k = 0; k < N_IN; k++)
            xmem[k] = rnd ? DW'($urandom) : xv;
        for (int a = 0; a < N_GRP*N_IN; a++)
            for (int l = 0; l < N_CH; l++)
                wmem[a][l*DW +: DW] = rnd ? DW'($urandom) : wv;
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_x_re"},      x_re,      0);
        check_val({pfx, "_w_re"},      w_re,      0);
        check_val({pfx, "_busy"},      busy,      0);
        check_val({pfx, "_done"},      done,      0);
        check_val({pfx, "_out_valid"}, out_valid, 0);
        check_val({pfx, "_x_addr"},    x_addr,    0);
        check_val({pfx, "_w_addr"},    w_addr,    0);
        check_val({pfx, "_out_data"},  out_data,  0);
        check_val({pfx, "_out_idx"},   out_idx,   0);
    endtask

    // One layer pass. Cycle 0 is the edge that accepts start.
    task automatic run_pass(input bit relu, input int stall_at, input int stall_len,
                            input bit poke_start, input int abort_at, input int exp_done);
        int cyc, n, done_cnt, done_at, stall_left;
        logic [DW-1:0] exp_d [N_OUT];
        for (int j = 0; j < N_OUT; j++) exp_d[j] = ref_out(j, relu);
        @(negedge clk);
        start = 1'b1; relu_en = relu; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        relu_en = ~relu;
        check_val("busy_after_start", busy, 1);
        cyc = 0; n = 0; done_cnt = 0; done_at = -1; stall_left = stall_len;
        while (cyc < 200 && (done_at < 0 || cyc < done_at + 5)) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (abort_at > 0 && cyc == abort_at) begin
                reset = 1'b0;
                #1;
                check_reset_state("abort");
                @(negedge clk); @(negedge clk);
                reset = 1'b1;
                out_ready = 1'b1;
                return;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
                check_val("busy_in_done", busy, 0);
            end
            if (out_valid) begin
                check_val("re_in_emit", x_re | w_re, 0);
                if (n >= N_OUT) begin
                    check_val("extra_result", out_valid, 0);
                    out_ready = 1'b1;
                end else begin
                    check_val("out_idx", out_idx, n);
                    check_val("out_data", out_data, exp_d[n]);
                    if (poke_start && n == 0) start = 1'b1;
                    if (n == stall_at && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                        n++;
                    end
                end
            end else begin
                out_ready = 1'b1;
            end
        end
        check_val("n_results", n, N_OUT);
        check_val("done_pulses", done_cnt, 1);
        check_val("done_cycle", done_at, exp_done);
        check_val("idle_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
        fill(16'h0000, 16'h0000, 1'b0);
        #3 reset = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        fill(16'h0100, 16'h0100, 1'b0);
        check_val("ref_unity", ref_out(0, 1'b0), 16'h0400);
        run_pass(1'b0, -1, 0, 1'b0, 0, PASS_CYC);

        fill(16'h7FFF, 16'h7FFF, 1'b0);
        run_pass(1'b0, -1, 0, 1'b0, 0, PASS_CYC);
        fill(16'h7FFF, 16'h8000, 1'b0);
        run_pass(1'b0, -1, 0, 1'b0, 0, PASS_CYC);

        fill(16'h0100, 16'hFF00, 1'b0);
        run_pass(1'b0, -1, 0, 1'b0, 0, PASS_CYC);
        run_pass(1'b1, -1, 0, 1'b0, 0, PASS_CYC);

        fill(16'h0100, 16'h0100, 1'b0);
        run_pass(1'b0, 1, 3, 1'b0, 0, PASS_CYC + 3);

        run_pass(1'b0, -1, 0, 1'b0, N_IN + 2 + N_CH + 1, PASS_CYC);
        run_pass(1'b0, -1, 0, 1'b0, 0, PASS_CYC);

        run_pass(1'b0, -1, 0, 1'b1, 0, PASS_CYC);

        for (int t = 0; t < 8; t++) begin
            int sl, sa;
            bit rl;
            fill(16'h0000, 16'h0000, 1'b1);
            sl = $urandom_range(0, 3);
            sa = $urandom_range(0, N_OUT - 1);
            rl = 1'($urandom_range(0, 1));
            run_pass(rl, sa, sl, 1'b0, 0, PASS_CYC + sl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
